bcounter32: RTL and testbench

BCOUNTER32 -- requirements
Module: bcounter32

---
 rtl/bcounter32_inc.sv | 44 ++++
 rtl/bcounter32.sv | 26 ++
 tb/tb_bcounter32.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bcounter32_inc.sv
// Carry-lookahead +1 incrementer, 32 bits, built from 4-bit groups.
// No arithmetic operator: each bit toggles when all lower bits are ones.
module bcounter32_inc (
  input  logic [31:0] a,
  output logic [31:0] y
);

  logic [7:0]      g;
  logic [3:0][7:0] pre;
  logic [7:0]      cin;
  logic [31:0]     run;

  for (genvar i = 0; i < 8; i++) begin : g_grp
    assign g[i] = &a[4*i +: 4];
  end

  assign pre[0] = g;

  // Kogge-Stone prefix AND over the eight group-all-ones flags
  for (genvar l = 0; l < 3; l++) begin : g_lvl
    for (genvar i = 0; i < 8; i++) begin : g_node
      if (i >= (1 << l)) begin : g_and
        assign pre[l+1][i] = pre[l][i] & pre[l][i-(1<<l)];
      end else begin : g_pass
        assign pre[l+1][i] = pre[l][i];
      end
    end
  end

  assign cin = {pre[3][6:0], 1'b1};

  for (genvar gi = 0; gi < 8; gi++) begin : g_bits
    for (genvar b = 0; b < 4; b++) begin : g_bit
      if (b == 0) begin : g_lsb
        assign run[4*gi] = cin[gi];
      end else begin : g_up
        assign run[4*gi+b] = cin[gi] & (&a[4*gi +: b]);
      end
    end
  end

  assign y = a ^ run;

endmodule

// File: rtl/bcounter32.sv
// Free-running 32-bit binary counter, async active-low reset.
// q comes straight from the count register.
module bcounter32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  bcounter32_inc u_inc (
    .a (q_q),
    .y (q_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: tb/tb_bcounter32.sv
// Bench for bcounter32: cycle-level model compare plus directed
// reset, count, wrap, async-reset and incrementer carry vectors.
module tb_bcounter32;

  logic        clk;
  logic        reset;
  logic [31:0] q;
  logic [31:0] ia;
  logic [31:0] iy;

  logic [31:0] m;
  logic        chk_en;
  int          n_cmp;
  int          n_bad;

  bcounter32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (q)
  );

  bcounter32_inc u_inc (
    .a (ia),
    .y (iy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the count is simply the number of edges since reset, mod 2^32
  always @(posedge clk or negedge reset) begin
    if (!reset) m = 32'd0;
    else        m = m + 32'd1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (q !== m) begin
        n_bad++;
        $display("FAIL model_q t=%0t got %h want %h", $time, q, m);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  logic [31:0] prev;
  logic [31:0] wrap_exp [3];
  logic [31:0] ea;
  bit          found;

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    chk_en = 1'b0;
    m      = 32'd0;
    ia     = 32'd0;
    reset  = 1'b1;
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;
    chk("reset_async", q, 32'h0);

    // hold reset across three clocks
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", q, 32'h0);
    end
    reset = 1'b1;

    // count: sample before each of 50 rising edges
    prev = 32'hFFFFFFFF;
    for (int i = 0; i < 50; i++) begin
      if (i > 0) @(negedge clk);
      chk("count_seq", q, 32'(i));
      chk("count_step", q, prev + 32'd1);
      prev = q;
    end

    // async reset mid-cycle at 0x1234
    found = 1'b0;
    for (int i = 0; i < 6000 && !found; i++) begin
      @(negedge clk);
      if (q == 32'h1234) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL reach_1234 got %h want %h", q, 32'h1234);
    end
    #2 reset = 1'b0;
    #1 chk("async_clear", q, 32'h0);
    @(negedge clk);
    chk("async_hold", q, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("resume_1", q, 32'h1);

    // wrap: preload FFFFFFFE then three edges
    #1 force dut.q_q = 32'hFFFFFFFE;
    m = 32'hFFFFFFFE;
    #1 release dut.q_q;
    #1 chk("preload", q, 32'hFFFFFFFE);
    wrap_exp[0] = 32'hFFFFFFFF;
    wrap_exp[1] = 32'h00000000;
    wrap_exp[2] = 32'h00000001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wrap", q, wrap_exp[i]);
    end

    // incrementer carry chain
    chk_en = 1'b0;
    ia = 32'h0000000F;
    #1 chk("inc_0f", iy, 32'h00000010);
    ia = 32'h7FFFFFFF;
    #1 chk("inc_7fff", iy, 32'h80000000);
    ia = 32'hFFFFFFFF;
    #1 chk("inc_wrap", iy, 32'h00000000);
    for (int k = 0; k <= 32; k++) begin
      ea = 32'((64'd1 << k) - 64'd1);
      ia = ea;
      #1 chk("inc_ones", iy, ea + 32'd1);
    end
    for (int i = 0; i < 1000; i++) begin
      ea = $urandom;
      ia = ea;
      #1 chk("inc_rand", iy, ea + 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
